adder_result_checker: RTL and testbench
=======================================

// Module: adder_result_checker
// PURPOSE
//   In-order self-checking scoreboard that sits directly downstream of pipelined_adder.
//   Taps the operands issued to the adder and queues their expected sums.
//   Pops one expected sum per adder result, compares, and keeps pass/fail counters.
//   Captures the first failing vector for the on-chip debug core.
// PARAMETERS
//   W           128  operand/result width
//   DEPTH       8    expected-sum queue depth; power of 2, >= adder stages + 1
//   CW          32   width of check/error counters
//   STOP_ON_ERR 1    1: halt checking at first mismatch; 0: keep running
// PORTS
//   clk        in   1           clock; all logic on posedge
//   rstn       in   1           async active-low reset
//   clr        in   1           sync clear of queue, counters and flags
//   op1        in   W           operand A as issued to the adder
//   op2        in   W           operand B as issued to the adder
//   op_valid   in   1           op1/op2 issued this cycle; push expected sum
//   res        in   W           adder result
//   res_valid  in   1           res valid this cycle; pop and compare
//   error      out  1           sticky: at least one mismatch seen
//   proto_err  out  1           sticky: queue underflow or overflow
//   chk_cnt    out  CW          results compared
//   err_cnt    out  CW          mismatching results
//   fail_exp   out  W           expected value of first mismatch
//   fail_got   out  W           received value of first mismatch
//   inflight   out  log2(DEPTH)+1  current queue occupancy
//   halted     out  1           FSM is in HALT
// BEHAVIOUR
//   Reset (rstn=0, async)
//     - All outputs go to 0 immediately; queue empty; FSM enters RUN.
//   Expected value
//     - exp = (op1 + op2) mod 2^W; carry-out discarded (wrap-around is legal).
//   Push and pop
//     - Push: on op_valid in RUN, exp is written at the tail.
//     - Pop: on res_valid in RUN, the head is read and compared with res.
//     - Push and pop in the same cycle are both accepted; inflight is unchanged.
//     - A same-cycle push never satisfies a pop.
//   Underflow
//     - res_valid while inflight==0 (pre-push value) sets proto_err.
//     - No compare is made; counters are unchanged.
//   Overflow
//     - op_valid with inflight==DEPTH and no same-cycle pop sets proto_err.
//     - The push is dropped.
//   Compare pipeline (1 cycle)
//     - Registered one cycle after a valid pop.
//     - chk_cnt increments; on mismatch err_cnt increments and error sets.
//     - Both counters saturate at all-ones.
//     - fail_exp/fail_got load only on the first mismatch while error==0.
//   FSM
//     - RUN -> HALT when the compare stage flags a mismatch and STOP_ON_ERR=1.
//     - HALT: ignores op_valid/res_valid; counters, queue and flags frozen; halted=1.
//     - Any state -> RUN on clr.
//     - With STOP_ON_ERR=0 the FSM never leaves RUN.
//   clr (synchronous)
//     - Flushes the queue and zeroes all outputs, including the compare stage in flight.
//     - Has priority over same-cycle op_valid/res_valid; those are dropped.
//   Reset mid-operation
//     - Asserting rstn low discards in-flight compares.
//     - No spurious count is produced after release.
// TESTING
//   1. Feed 16 vectors op1=LFSR value, op2=~op1 through a 4-stage adder.
//      -> chk_cnt=16, err_cnt=0, error=0, inflight=0 at end.
//   2. Flip bit0 of the 3rd result (exp all-ones, got all-ones^1), STOP_ON_ERR=1.
//      -> error=1 one cycle after that res_valid; fail_got=...FE; err_cnt=1.
//      -> halted=1; chk_cnt frozen at 3.
//   3. op1=all-ones, op2=1, res=0.
//      -> pass; chk_cnt=1, error=0 (wrap legal).
//   4. res_valid with empty queue.
//      -> proto_err=1, chk_cnt=0.
//      Then DEPTH+1 pushes with no pops.
//      -> inflight=DEPTH, 9th push dropped.
//   5. At inflight=DEPTH, assert op_valid and res_valid together.
//      -> proto_err stays 0; inflight stays DEPTH.
//   6. Drop rstn mid-stream with 3 entries queued.
//      -> all outputs 0 without a clock edge.
//      Repeat with clr plus same-cycle res_valid.
//      -> zeroed one cycle later; no count from the dropped pop.

Source files
------------

// File: rtl/adder_result_checker.sv
// In-order scoreboard for pipelined_adder: queues expected sums, compares them with results,
// counts passes and fails, and captures the first failing vector for debug.
module adder_result_checker #(
  parameter int unsigned W           = 128,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned CW          = 32,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic [W-1:0]             op1,
  input  logic [W-1:0]             op2,
  input  logic                     op_valid,
  input  logic [W-1:0]             res,
  input  logic                     res_valid,
  output logic                     error,
  output logic                     proto_err,
  output logic [CW-1:0]            chk_cnt,
  output logic [CW-1:0]            err_cnt,
  output logic [W-1:0]             fail_exp,
  output logic [W-1:0]             fail_got,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     halted
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CntW = AW + 1;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cmp_vld_q, cmp_vld_d;
  logic [W-1:0]    cmp_exp_q, cmp_exp_d, cmp_got_q, cmp_got_d;
  logic            error_q, error_d, proto_q, proto_d;
  logic [CW-1:0]   chk_q, chk_d, errc_q, errc_d;
  logic [W-1:0]    fexp_q, fexp_d, fgot_q, fgot_d;

  logic         run, full, empty, pop, push, underflow, overflow, mismatch, mem_we;
  logic [W-1:0] exp_sum;

  always_comb begin
    run       = (state_q == StRun);
    full      = (cnt_q == CntW'(DEPTH));
    empty     = (cnt_q == '0);
    pop       = run & res_valid & ~empty;
    // A full queue still takes a push when the same cycle frees the head slot.
    push      = run & op_valid & (~full | pop);
    underflow = run & res_valid & empty;
    overflow  = run & op_valid & full & ~pop;
    mismatch  = cmp_vld_q & (cmp_exp_q != cmp_got_q);
    exp_sum   = op1 + op2;
    mem_we    = push & ~clr;
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    cmp_vld_d = cmp_vld_q;
    cmp_exp_d = cmp_exp_q;
    cmp_got_d = cmp_got_q;
    error_d   = error_q;
    proto_d   = proto_q;
    chk_d     = chk_q;
    errc_d    = errc_q;
    fexp_d    = fexp_q;
    fgot_d    = fgot_q;

    if (clr) begin
      state_d   = StRun;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      cmp_vld_d = 1'b0;
      cmp_exp_d = '0;
      cmp_got_d = '0;
      error_d   = 1'b0;
      proto_d   = 1'b0;
      chk_d     = '0;
      errc_d    = '0;
      fexp_d    = '0;
      fgot_d    = '0;
    end else if (run) begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      cnt_d = cnt_q + CntW'(1);
      else if (pop && !push) cnt_d = cnt_q - CntW'(1);

      cmp_vld_d = pop;
      if (pop) begin
        cmp_exp_d = mem[rd_ptr_q];
        cmp_got_d = res;
      end

      if (cmp_vld_q) begin
        if (chk_q != '1) chk_d = chk_q + CW'(1);
        if (mismatch) begin
          if (errc_q != '1) errc_d = errc_q + CW'(1);
          if (!error_q) begin
            fexp_d = cmp_exp_q;
            fgot_d = cmp_got_q;
          end
          error_d = 1'b1;
          if (STOP_ON_ERR) state_d = StHalt;
        end
      end

      if (underflow || overflow) proto_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StRun;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      cmp_vld_q <= 1'b0;
      cmp_exp_q <= '0;
      cmp_got_q <= '0;
      error_q   <= 1'b0;
      proto_q   <= 1'b0;
      chk_q     <= '0;
      errc_q    <= '0;
      fexp_q    <= '0;
      fgot_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_exp_q <= cmp_exp_d;
      cmp_got_q <= cmp_got_d;
      error_q   <= error_d;
      proto_q   <= proto_d;
      chk_q     <= chk_d;
      errc_q    <= errc_d;
      fexp_q    <= fexp_d;
      fgot_q    <= fgot_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= exp_sum;
  end

  assign error     = error_q;
  assign proto_err = proto_q;
  assign chk_cnt   = chk_q;
  assign err_cnt   = errc_q;
  assign fail_exp  = fexp_q;
  assign fail_got  = fgot_q;
  assign inflight  = cnt_q;
  assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_adder_result_checker.sv
// Randomized self-checking bench for adder_result_checker with a queue-based reference model.
module tb_adder_result_checker;

  localparam int unsigned W     = 128;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 32;

  logic            clk = 1'b0;
  logic            rstn, clr, op_valid, res_valid;
  logic [W-1:0]    op1, op2, res;
  logic            error, proto_err, halted;
  logic [CW-1:0]   chk_cnt, err_cnt;
  logic [W-1:0]    fail_exp, fail_got;
  logic [$clog2(DEPTH):0] inflight;

  adder_result_checker #(.W(W), .DEPTH(DEPTH), .CW(CW), .STOP_ON_ERR(1'b1)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .op1(op1), .op2(op2), .op_valid(op_valid),
    .res(res), .res_valid(res_valid), .error(error), .proto_err(proto_err),
    .chk_cnt(chk_cnt), .err_cnt(err_cnt), .fail_exp(fail_exp), .fail_got(fail_got),
    .inflight(inflight), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  string phase = "init";

  // Reference model state
  logic [W-1:0]  m_q[$];
  logic          m_pend, m_error, m_proto, m_halt;
  logic [W-1:0]  m_pend_exp, m_pend_got, m_fexp, m_fgot;
  logic [CW-1:0] m_chk, m_err;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got=%0h exp=%0h", phase, tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_pend = 0; m_error = 0; m_proto = 0; m_halt = 0;
    m_pend_exp = '0; m_pend_got = '0; m_fexp = '0; m_fgot = '0;
    m_chk = '0; m_err = '0;
  endtask

  task automatic model_step(input logic ov, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic rv, input logic [W-1:0] r, input logic c);
    logic          nxt_halt;
    logic [W-1:0]  s;
    if (c) begin
      model_clear();
      return;
    end
    if (m_halt) return;
    nxt_halt = 0;
    if (m_pend) begin
      if (m_chk != '1) m_chk++;
      if (m_pend_exp != m_pend_got) begin
        if (m_err != '1) m_err++;
        if (!m_error) begin
          m_fexp = m_pend_exp;
          m_fgot = m_pend_got;
        end
        m_error  = 1;
        nxt_halt = 1;
      end
    end
    m_pend = 0;
    // Pop is resolved before push so a same-cycle push never feeds the pop.
    if (rv) begin
      if (m_q.size() == 0) m_proto = 1;
      else begin
        m_pend     = 1;
        m_pend_exp = m_q.pop_front();
        m_pend_got = r;
      end
    end
    if (ov) begin
      if (m_q.size() >= DEPTH) m_proto = 1;
      else begin
        s = a + b;
        m_q.push_back(s);
      end
    end
    m_halt = nxt_halt;
  endtask

  task automatic compare_all();
    check("error", W'(error), W'(m_error));
    check("proto_err", W'(proto_err), W'(m_proto));
    check("chk_cnt", W'(chk_cnt), W'(m_chk));
    check("err_cnt", W'(err_cnt), W'(m_err));
    check("fail_exp", fail_exp, m_fexp);
    check("fail_got", fail_got, m_fgot);
    check("inflight", W'(inflight), W'(m_q.size()));
    check("halted", W'(halted), W'(m_halt));
  endtask

  task automatic step(input logic ov, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic rv, input logic [W-1:0] r, input logic c);
    op_valid = ov; op1 = a; op2 = b; res_valid = rv; res = r; clr = c;
    @(posedge clk);
    model_step(ov, a, b, rv, r, c);
    #1;
    compare_all();
    op_valid = 0; res_valid = 0; clr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, 0);
  endtask

  task automatic do_clr();
    step(0, '0, '0, 0, '0, 1);
  endtask

  // Streams n vectors op2=~op1 through a 4-stage adder; result number bad_idx gets bit0 flipped.
  task automatic stream(input int n, input int bad_idx);
    logic [W-1:0] a[16];
    logic [W-1:0] r;
    for (int i = 0; i < n; i++) a[i] = rand_w();
    for (int t = 0; t < n + 6; t++) begin
      r = '0;
      if (t >= 4 && t - 4 < n) begin
        r = a[t-4] + ~a[t-4];
        if (t - 4 == bad_idx) r[0] = ~r[0];
      end
      step(t < n, (t < n) ? a[t] : '0, (t < n) ? ~a[t] : '0, t >= 4 && t - 4 < n, r, 0);
      if (bad_idx == 2 && t == 6) check("err_before", W'(error), W'(0));
      if (bad_idx == 2 && t == 7) check("err_after", W'(error), W'(1));
    end
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] r;
    logic         ov, rv, c;
    ones = '1;
    rstn = 0; clr = 0; op_valid = 0; res_valid = 0; op1 = '0; op2 = '0; res = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    phase = "reset";
    compare_all();
    #4 rstn = 1;

    phase = "t1";
    stream(16, -1);
    check("t1_chk", W'(chk_cnt), W'(16));
    check("t1_err", W'(err_cnt), W'(0));
    check("t1_infl", W'(inflight), W'(0));

    phase = "t2";
    do_clr();
    stream(16, 2);
    check("t2_err", W'(error), W'(1));
    check("t2_fgot", fail_got, ones ^ W'(1));
    check("t2_fexp", fail_exp, ones);
    check("t2_errc", W'(err_cnt), W'(1));
    check("t2_halt", W'(halted), W'(1));
    check("t2_chk", W'(chk_cnt), W'(3));

    phase = "t3";
    do_clr();
    check("t3_unhalt", W'(halted), W'(0));
    step(1, ones, W'(1), 0, '0, 0);
    idle(3);
    step(0, '0, '0, 1, '0, 0);
    idle(2);
    check("t3_chk", W'(chk_cnt), W'(1));
    check("t3_err", W'(error), W'(0));

    phase = "t4";
    do_clr();
    step(0, '0, '0, 1, rand_w(), 0);
    check("t4_proto", W'(proto_err), W'(1));
    check("t4_chk", W'(chk_cnt), W'(0));
    for (int i = 0; i < DEPTH + 1; i++) step(1, rand_w(), rand_w(), 0, '0, 0);
    check("t4_infl", W'(inflight), W'(DEPTH));

    phase = "t5";
    do_clr();
    for (int i = 0; i < DEPTH; i++) step(1, rand_w(), rand_w(), 0, '0, 0);
    step(1, rand_w(), rand_w(), 1, m_q[0], 0);
    check("t5_proto", W'(proto_err), W'(0));
    check("t5_infl", W'(inflight), W'(DEPTH));
    for (int i = 0; i < DEPTH; i++) step(0, '0, '0, 1, m_q[0], 0);
    idle(2);
    check("t5_chk", W'(chk_cnt), W'(DEPTH + 1));
    check("t5_err", W'(error), W'(0));

    phase = "t6";
    do_clr();
    for (int i = 0; i < 3; i++) step(1, rand_w(), rand_w(), 0, '0, 0);
    step(0, '0, '0, 1, m_q[0], 0);
    #3 rstn = 0;
    #1;
    model_clear();
    compare_all();
    #3 rstn = 1;
    idle(3);
    check("t6_chk", W'(chk_cnt), W'(0));
    for (int i = 0; i < 3; i++) step(1, rand_w(), rand_w(), 0, '0, 0);
    step(0, '0, '0, 1, m_q[0], 1);
    check("t6_clr_infl", W'(inflight), W'(0));
    idle(3);
    check("t6_clr_chk", W'(chk_cnt), W'(0));

    phase = "rand";
    do_clr();
    for (int i = 0; i < 400; i++) begin
      ov = ($urandom_range(0, 99) < 50);
      rv = ($urandom_range(0, 99) < 50);
      c  = ($urandom_range(0, 99) < 3);
      r  = (m_q.size() > 0 && $urandom_range(0, 99) < 95) ? m_q[0] : rand_w();
      step(ov, rand_w(), rand_w(), rv, r, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
